// File: rtl/branch_update_queue.sv
// branch_update_queue: in-order record of predicted conditional branches from fetch, retired as the ROB commits outcomes.
// Latency: an accepted resolve produces update/mispredict pulses one cycle later (registered on the popping edge).
// Backpressure: pushReady drops at DEPTH entries; a push while full is dropped, even alongside a pop (no bypass).
// Optional: define BRANCH_STATS_EN to add statResolved/statMispredict counters and the sticky statUnderflow flag.
module branch_update_queue #(
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic        pushValid,
  input  logic [31:0] pushAddr,
  input  logic        pushPred,
  input  logic [31:0] pushTarget,
  output logic        pushReady,
  input  logic        resolveValid,
  input  logic        resolveTaken,
  input  logic        flushIn,
  output logic        updateValid,
  output logic [31:0] updateInstr,
  output logic        taken,
  output logic        mispredict,
  output logic [31:0] redirectPc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] statResolved,
  output logic [31:0] statMispredict,
  output logic        statUnderflow
`endif
);

  typedef struct packed {
    logic [31:0] addr;
    logic        pred;
    logic [31:0] target;
  } entry_t;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  entry_t                entryMem [DEPTH];
  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] tail;
  logic [ADDR_WIDTH:0]   count;

  entry_t headEntry;
  entry_t newEntry;
  logic   resolveFire;
  logic   isMispredict;
  logic   pushFire;
  logic   clearQueue;

  assign pushReady = (count != FULL_COUNT);
  assign headEntry = entryMem[head];
  assign newEntry  = '{addr: pushAddr, pred: pushPred, target: pushTarget};

  // A flush kills the resolve; a mispredict makes any same-cycle push wrong-path, so it is dropped.
  always_comb begin
    resolveFire  = resolveValid && (count != '0) && !flushIn;
    isMispredict = resolveFire && (resolveTaken != headEntry.pred);
    pushFire     = pushValid && pushReady && !flushIn && !isMispredict;
    clearQueue   = flushIn || isMispredict;
  end

  // Entry payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clockIn) begin
    if (pushFire) begin
      entryMem[tail] <= newEntry;
    end
  end

  // Head/tail/occupancy bookkeeping; a flush or mispredict empties the queue in one edge.
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clearQueue) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (resolveFire) head <= head + PTR_ONE;
      if (pushFire)    tail <= tail + PTR_ONE;
      if (pushFire && !resolveFire)      count <= count + CNT_ONE;
      else if (!pushFire && resolveFire) count <= count - CNT_ONE;
    end
  end

  // Training and redirect outputs; pulses last one cycle, payload fields hold between resolves.
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      updateValid <= 1'b0;
      updateInstr <= '0;
      taken       <= 1'b0;
      mispredict  <= 1'b0;
      redirectPc  <= '0;
    end else begin
      updateValid <= resolveFire;
      mispredict  <= isMispredict;
      if (resolveFire) begin
        updateInstr <= headEntry.addr;
        taken       <= resolveTaken;
        redirectPc  <= resolveTaken ? headEntry.target : headEntry.addr + 32'd4;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  // Lifetime counters survive flushes; underflow latches any resolve seen while empty.
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      statResolved   <= '0;
      statMispredict <= '0;
      statUnderflow  <= 1'b0;
    end else begin
      if (resolveFire)  statResolved   <= statResolved + 32'd1;
      if (isMispredict) statMispredict <= statMispredict + 32'd1;
      if (resolveValid && (count == '0)) statUnderflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// Scoreboard bench for branch_update_queue: directed scenarios followed by random traffic.
// Expected training/redirect records come from a queue-based model and are popped by a separate monitor.
// Build with BRANCH_STATS_EN defined to include the statistics scenario.
module tb_branch_update_queue;

  localparam int DEPTH = 8;

  logic        clockIn = 1'b0;
  logic        resetIn = 1'b1;
  logic        pushValid = 1'b0;
  logic [31:0] pushAddr = '0;
  logic        pushPred = 1'b0;
  logic [31:0] pushTarget = '0;
  logic        pushReady;
  logic        resolveValid = 1'b0;
  logic        resolveTaken = 1'b0;
  logic        flushIn = 1'b0;
  logic        updateValid;
  logic [31:0] updateInstr;
  logic        taken;
  logic        mispredict;
  logic [31:0] redirectPc;
`ifdef BRANCH_STATS_EN
  logic [31:0] statResolved;
  logic [31:0] statMispredict;
  logic        statUnderflow;
`endif

  branch_update_queue #(.ADDR_WIDTH(3)) dut (
    .clockIn(clockIn), .resetIn(resetIn),
    .pushValid(pushValid), .pushAddr(pushAddr), .pushPred(pushPred), .pushTarget(pushTarget),
    .pushReady(pushReady),
    .resolveValid(resolveValid), .resolveTaken(resolveTaken), .flushIn(flushIn),
    .updateValid(updateValid), .updateInstr(updateInstr), .taken(taken),
    .mispredict(mispredict), .redirectPc(redirectPc)
`ifdef BRANCH_STATS_EN
    , .statResolved(statResolved), .statMispredict(statMispredict), .statUnderflow(statUnderflow)
`endif
  );

  always #5 clockIn = ~clockIn;

  typedef struct {
    logic [31:0] addr;
    logic        pred;
    logic [31:0] target;
  } ent_t;

  typedef struct {
    logic [31:0] instr;
    logic        tkn;
    logic        misp;
    logic [31:0] redirect;
  } exp_t;

  ent_t        model[$];
  exp_t        expQ[$];
  int          passCnt = 0;
  int          totalCnt = 0;
  int unsigned resCnt = 0;
  int unsigned mispCnt = 0;
  bit          underflow = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  // Monitor: whenever the DUT presents a training pulse, compare it against the oldest expectation.
  always @(negedge clockIn) begin
    if (!resetIn) begin
      if (updateValid) begin
        if (expQ.size() == 0) begin
          chk("spurious_update", {31'd0, updateValid}, 32'd0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          chk("updateInstr", updateInstr, e.instr);
          chk("taken", {31'd0, taken}, {31'd0, e.tkn});
          chk("mispredict", {31'd0, mispredict}, {31'd0, e.misp});
          if (e.misp) chk("redirectPc", redirectPc, e.redirect);
        end
      end else if (mispredict) begin
        chk("mispredict_without_update", {31'd0, mispredict}, 32'd0);
      end
    end
  end

  // One clock of stimulus; the model decides what the queue does and records expected pulses.
  task automatic step(input logic pv, input logic [31:0] pa, input logic pp, input logic [31:0] pt,
                      input logic rv, input logic rt, input logic fl);
    bit canPop, canPush, misp;
    ent_t n;
    pushValid = pv; pushAddr = pa; pushPred = pp; pushTarget = pt;
    resolveValid = rv; resolveTaken = rt; flushIn = fl;
    chk("pushReady", {31'd0, pushReady}, {31'd0, model.size() != DEPTH});
    canPop = rv && (model.size() != 0) && !fl;
    misp = 0;
    if (rv && model.size() == 0) underflow = 1;
    if (canPop) begin
      exp_t e;
      e.instr    = model[0].addr;
      e.tkn      = rt;
      e.misp     = (rt != model[0].pred);
      e.redirect = rt ? model[0].target : model[0].addr + 32'd4;
      expQ.push_back(e);
      misp = e.misp;
      resCnt++;
      if (misp) mispCnt++;
    end
    canPush = pv && (model.size() != DEPTH) && !fl && !misp;
    if (fl || misp) begin
      model.delete();
    end else begin
      if (canPop) void'(model.pop_front());
      if (canPush) begin
        n.addr = pa; n.pred = pp; n.target = pt;
        model.push_back(n);
      end
    end
    @(posedge clockIn);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'h0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic push(input logic [31:0] a, input logic p, input logic [31:0] t);
    step(1, a, p, t, 0, 0, 0);
  endtask

  task automatic resolve(input logic rt);
    step(0, 32'h0, 0, 32'h0, 1, rt, 0);
  endtask

  // Assert reset between edges and check that state is cleared without waiting for a clock.
  task automatic asyncReset(input string tag);
    #2;
    resetIn = 1'b1;
    expQ.delete();
    model.delete();
    resCnt = 0; mispCnt = 0; underflow = 0;
    #1;
    chk({tag, "_updateValid"}, {31'd0, updateValid}, 32'd0);
    chk({tag, "_updateInstr"}, updateInstr, 32'd0);
    chk({tag, "_taken"}, {31'd0, taken}, 32'd0);
    chk({tag, "_mispredict"}, {31'd0, mispredict}, 32'd0);
    chk({tag, "_redirectPc"}, redirectPc, 32'd0);
    chk({tag, "_pushReady"}, {31'd0, pushReady}, 32'd1);
`ifdef BRANCH_STATS_EN
    chk({tag, "_statResolved"}, statResolved, 32'd0);
    chk({tag, "_statMispredict"}, statMispredict, 32'd0);
    chk({tag, "_statUnderflow"}, {31'd0, statUnderflow}, 32'd0);
`endif
    @(posedge clockIn);
    #1;
    resetIn = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic p, rt, pv, rv, fl;

    #1;
    chk("reset_updateValid", {31'd0, updateValid}, 32'd0);
    chk("reset_mispredict", {31'd0, mispredict}, 32'd0);
    chk("reset_redirectPc", redirectPc, 32'd0);
    chk("reset_pushReady", {31'd0, pushReady}, 32'd1);
    @(posedge clockIn); @(posedge clockIn); #1;
    resetIn = 1'b0;

    // Correctly predicted taken branch.
    push(32'h100, 1, 32'h140);
    resolve(1);
    idle(1);

    // Mispredict on not-taken prediction discards the younger branch; a following resolve is ignored.
    push(32'h200, 0, 32'h180);
    push(32'h204, 1, 32'h300);
    resolve(1);
    resolve(1);
    idle(1);

    // Mispredict on taken prediction redirects to the fall-through address.
    push(32'h400, 1, 32'h500);
    resolve(0);
    idle(1);

    // Fill, overflow, push+pop while full, drain, then steady push/pop through the pointer wrap.
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i * 4), 1, 32'h2000);
    push(32'h1FF0, 1, 32'h2000);
    step(1, 32'h1FF4, 1, 32'h2000, 1, 1, 0);
    for (int i = 0; i < DEPTH - 1; i++) resolve(1);
    push(32'h3000, 0, 32'h3800);
    for (int i = 1; i <= DEPTH; i++) step(1, 32'h3000 + 32'(i * 4), 0, 32'h3800, 1, 0, 0);
    resolve(0);
    idle(1);

    // Flush with three entries queued beats a simultaneous resolve and push.
    for (int i = 0; i < 3; i++) push(32'h5000 + 32'(i * 4), 1, 32'h6000);
    step(1, 32'h5100, 1, 32'h6000, 1, 1, 1);
    idle(1);
    for (int i = 0; i < DEPTH + 1; i++) push(32'h7000 + 32'(i * 4), 0, 32'h7800);
    step(0, 32'h0, 0, 32'h0, 0, 0, 1);
    idle(1);

    // Random traffic; resolves mostly agree with the prediction so the queue builds depth.
    for (int c = 0; c < 600; c++) begin
      a  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      p  = 1'($urandom_range(0, 1));
      pv = ($urandom_range(0, 9) < 7);
      rv = ($urandom_range(0, 9) < 4);
      fl = ($urandom_range(0, 39) == 0);
      if (model.size() != 0 && $urandom_range(0, 4) != 0) rt = model[0].pred;
      else rt = 1'($urandom_range(0, 1));
      step(pv, a, p, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, rv, rt, fl);
    end
    step(0, 32'h0, 0, 32'h0, 0, 0, 1);
    idle(2);
`ifdef BRANCH_STATS_EN
    chk("random_statResolved", statResolved, resCnt);
    chk("random_statMispredict", statMispredict, mispCnt);
    chk("random_statUnderflow", {31'd0, statUnderflow}, {31'd0, underflow});
`endif

    asyncReset("reset_clean");

    // Five resolves, two of them mispredicts, then one resolve while empty.
    push(32'h8000, 1, 32'h8100); resolve(1);
    push(32'h8004, 1, 32'h8200); resolve(0);
    push(32'h8008, 0, 32'h8300); resolve(0);
    push(32'h800C, 0, 32'h8400); resolve(1);
    push(32'h8010, 1, 32'h8500); resolve(1);
    resolve(1);
    idle(1);
`ifdef BRANCH_STATS_EN
    chk("stat_resolved_5", statResolved, 32'd5);
    chk("stat_mispredict_2", statMispredict, 32'd2);
    chk("stat_underflow_1", {31'd0, statUnderflow}, 32'd1);
    chk("stat_model_resolved", statResolved, resCnt);
`endif

    // Reset arriving just after a training pulse clears everything immediately.
    push(32'h9000, 0, 32'h9400);
    resolve(1);
    chk("pre_reset_updateValid", {31'd0, updateValid}, 32'd1);
    asyncReset("reset_midop");

    push(32'hA000, 1, 32'hA400);
    resolve(1);
    idle(3);
    chk("pending_updates", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
